// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg
// Shared encodings for the CPU run controller: FSM states and run modes.
// Ports: none (package).
// Optional feature macro used elsewhere in this slice: CPU_RUN_CTRL_BREAK_EN.

package cpu_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RST_HOLD = 2'd1,
        ST_RUN      = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    // 2'b11 is reserved and decodes as free-run.
    typedef enum logic [1:0] {
        MODE_FREE = 2'b00,
        MODE_STEP = 2'b01,
        MODE_RUNN = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

endpackage

// File: rtl/cpu_run_edge_det.sv
// cpu_run_edge_det
// Synchronous rising-edge detector; the history flop clears asynchronously.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low clear
//   sig    in   level input (assumed synchronous to clk)
//   rise   out  high for the cycle in which sig is 1 and was 0 last cycle

module cpu_run_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run controller for a CPU core: sequences core reset, latches the start PC,
// gates the core clock enable (free-run / single-step / run-N), counts
// executed cycles, applies a watchdog and captures the core result on halt.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                launch/restart request (rising edge)
//   mode                 00 free, 01 single-step, 10 run-N, 11 as free
//   step                 single-step request (rising edge)
//   run_len              cycle budget for run-N
//   pc_init_in           start PC, latched on start
//   halt_req, result_in  core halt indication and result bus
//   core_rst_n           registered active-low core reset
//   core_clk_en          registered core clock enable
//   pc_init              latched start PC
//   cycle_cnt            executed cycles (saturating)
//   result_q             result captured on entry to HALT
//   state, done, timeout FSM state, HALT flag, watchdog-caused halt
// Optional (macro CPU_RUN_CTRL_BREAK_EN):
//   pc_in, brk_addr, brk_en  core PC, breakpoint address and enable
//   brk_hit                  halt was caused by the breakpoint
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | after reset, core held in reset, waiting for start
// ST_RST_HOLD | core reset asserted for RST_CYCLES cycles
// ST_RUN      | core running, clock enable gated by mode
// ST_HALT     | core stopped, result captured, waiting for restart

module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                CNT_W      = 32,
    parameter int                RST_CYCLES = 5,
    parameter logic [CNT_W-1:0]  WDOG_LIMIT = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              step,
    input  logic [CNT_W-1:0]  run_len,
    input  logic [ADDR_W-1:0] pc_init_in,
    input  logic              halt_req,
    input  logic [DATA_W-1:0] result_in,
`ifdef CPU_RUN_CTRL_BREAK_EN
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] brk_addr,
    input  logic              brk_en,
    output logic              brk_hit,
`endif
    output logic              core_rst_n,
    output logic              core_clk_en,
    output logic [ADDR_W-1:0] pc_init,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [DATA_W-1:0] result_q,
    output logic [1:0]        state,
    output logic              done,
    output logic              timeout
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);

    state_t             state_q;
    mode_t              mode_q;
    logic [CNT_W-1:0]   run_len_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               start_rise;
    logic               step_rise;
    logic               halt_hit;
    logic               brk_cond;
    logic               runn_hit;
    logic               wdog_hit;
    logic               stop_run;

    cpu_run_edge_det u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (start),
        .rise  (start_rise)
    );

    cpu_run_edge_det u_step_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (step),
        .rise  (step_rise)
    );

    // Count after this cycle; halt decisions compare against it so the
    // HALT transition lands in the same cycle the count reaches its target.
    assign cnt_next = (core_clk_en && (cycle_cnt != '1)) ? cycle_cnt + CNT_W'(1)
                                                         : cycle_cnt;

    assign halt_hit = halt_req && core_clk_en;
`ifdef CPU_RUN_CTRL_BREAK_EN
    assign brk_cond = brk_en && core_clk_en && (pc_in == brk_addr);
`else
    assign brk_cond = 1'b0;
`endif
    assign runn_hit = (mode_q == MODE_RUNN) && (cnt_next == run_len_q);
    assign wdog_hit = (cnt_next == WDOG_LIMIT);
    assign stop_run = halt_hit || brk_cond || runn_hit || wdog_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_FREE;
            run_len_q   <= '0;
            hold_cnt    <= '0;
            core_rst_n  <= 1'b0;
            core_clk_en <= 1'b0;
            pc_init     <= '0;
            cycle_cnt   <= '0;
            result_q    <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
`ifdef CPU_RUN_CTRL_BREAK_EN
            brk_hit     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start_rise) begin
                        state_q     <= ST_RST_HOLD;
                        mode_q      <= mode_t'(mode);
                        run_len_q   <= run_len;
                        pc_init     <= pc_init_in;
                        hold_cnt    <= HOLD_W'(RST_CYCLES);
                        core_rst_n  <= 1'b0;
                        core_clk_en <= 1'b0;
                        cycle_cnt   <= '0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
`ifdef CPU_RUN_CTRL_BREAK_EN
                        brk_hit     <= 1'b0;
`endif
                    end
                end

                ST_RST_HOLD: begin
                    if (hold_cnt == HOLD_W'(1)) begin
                        core_rst_n <= 1'b1;
                        if ((mode_q == MODE_RUNN) && (run_len_q == '0)) begin
                            // Empty budget: skip RUN entirely.
                            state_q     <= ST_HALT;
                            done        <= 1'b1;
                            result_q    <= result_in;
                            core_clk_en <= 1'b0;
                        end else begin
                            state_q     <= ST_RUN;
                            core_clk_en <= (mode_q != MODE_STEP);
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end

                ST_RUN: begin
                    cycle_cnt <= cnt_next;
                    if (stop_run) begin
                        state_q     <= ST_HALT;
                        done        <= 1'b1;
                        result_q    <= result_in;
                        core_clk_en <= 1'b0;
                        // Watchdog is the lowest-priority cause.
                        timeout     <= wdog_hit && !(halt_hit || brk_cond || runn_hit);
`ifdef CPU_RUN_CTRL_BREAK_EN
                        brk_hit     <= brk_cond && !halt_hit;
`endif
                    end else if (mode_q == MODE_STEP) begin
                        core_clk_en <= step_rise;
                    end else begin
                        core_clk_en <= 1'b1;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule
